dmem_arbiter: RTL and testbench

Single-port data-variable-memory arbiter sitting between the ARM core's data port and the DIP-driven IO read port that feeds the seven-segment display. Grants one memory access per cycle to either the CPU or the IO requester, with CPU priority and a bounded-starvation guarantee for IO. Drives a synchronous-read 128-word RAM and returns read data with a valid pulse. Stalls the CPU on any cycle its request loses arbitration.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_rsp_pipe.sv | 42 ++++
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Defines the priority state encoding, the counter width and the response tag bit positions.
package dmem_arbiter_pkg;

    typedef enum logic {
        CPU_PRI = 1'b0,
        IO_PRI  = 1'b1
    } pri_state_t;

    localparam int CNT_W   = 4;
    localparam int TAG_W   = 2;
    localparam int TAG_CPU = 0;
    localparam int TAG_IO  = 1;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Read-response stage: the tag is captured at grant, and the RAM data is returned the next cycle.
// Each data output holds its last returned value between valid pulses.
module dmem_rsp_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              io_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rvalid
);

    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] io_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag      <= '0;
            cpu_hold <= '0;
            io_hold  <= '0;
        end else begin
            tag[TAG_CPU] <= cpu_rd;
            tag[TAG_IO]  <= io_rd;
            if (tag[TAG_CPU]) cpu_hold <= mem_rdata;
            if (tag[TAG_IO])  io_hold  <= mem_rdata;
        end
    end

    // RAM output is only valid in the cycle after the access, so pass it through then and hold afterwards
    assign cpu_rvalid = tag[TAG_CPU];
    assign io_rvalid  = tag[TAG_IO];
    assign cpu_rdata  = tag[TAG_CPU] ? mem_rdata : cpu_hold;
    assign io_rdata   = tag[TAG_IO]  ? mem_rdata : io_hold;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port RAM arbiter between the CPU data port and the IO read port.
// The CPU has priority, and the IO port is force-granted after STARVE_MAX losing cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuStall,
    output logic [DATA_W-1:0] CpuRData,
    output logic              CpuRValid,
    input  logic              IoReq,
    input  logic [ADDR_W-1:0] IoAddr,
    output logic              IoGnt,
    output logic [DATA_W-1:0] IoRData,
    output logic              IoRValid,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    pri_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cpu_grant, io_grant, io_lose;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= CPU_PRI;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (io_lose) begin
                if (cnt != '1) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        cpu_grant = 1'b0;
        io_grant  = 1'b0;
        state_nxt = state;
        // Grants are suppressed while reset is held so that every output reads zero
        if (!RESET) begin
            case (state)
                CPU_PRI: begin
                    cpu_grant = CpuReq;
                    io_grant  = IoReq & ~CpuReq;
                end
                IO_PRI: begin
                    io_grant  = IoReq;
                    cpu_grant = CpuReq & ~IoReq;
                end
                default: ;
            endcase
        end
        io_lose = IoReq & ~io_grant & ~RESET;
        if (state == CPU_PRI && io_lose && cnt >= CNT_W'(STARVE_MAX - 1))
            state_nxt = IO_PRI;
        else if (state == IO_PRI && io_grant)
            state_nxt = CPU_PRI;
    end

    assign IoGnt    = io_grant;
    assign CpuStall = CpuReq & ~RESET & ~cpu_grant;
    assign MemEn    = cpu_grant | io_grant;
    assign MemWe    = cpu_grant & CpuWe;
    assign MemAddr  = cpu_grant ? CpuAddr : (io_grant ? IoAddr : '0);
    assign MemWData = cpu_grant ? CpuWData : '0;

    dmem_rsp_pipe #(.DATA_W(DATA_W)) u_rsp (
        .clk       (CLK),
        .rst       (RESET),
        .cpu_rd    (cpu_grant & ~CpuWe),
        .io_rd     (io_grant),
        .mem_rdata (MemRData),
        .cpu_rdata (CpuRData),
        .cpu_rvalid(CpuRValid),
        .io_rdata  (IoRData),
        .io_rvalid (IoRValid)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a table of per-cycle vectors and hand-built contention and reset sequences.
// Read data is predicted from a shadow memory and checked through a response queue.
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CpuReq = 1'b0, CpuWe = 1'b0, IoReq = 1'b0;
    logic [AW-1:0] CpuAddr = '0, IoAddr = '0;
    logic [DW-1:0] CpuWData = '0;
    logic          CpuStall, CpuRValid, IoGnt, IoRValid, MemEn, MemWe;
    logic [DW-1:0] CpuRData, IoRData, MemWData;
    logic [DW-1:0] MemRData = '0;
    logic [AW-1:0] MemAddr;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuStall(CpuStall), .CpuRData(CpuRData), .CpuRValid(CpuRValid),
        .IoReq(IoReq), .IoAddr(IoAddr), .IoGnt(IoGnt), .IoRData(IoRData), .IoRValid(IoRValid),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem  [128];
    logic [DW-1:0] smem [128];

    always @(posedge CLK) begin
        if (MemEn) begin
            if (MemWe) mem[MemAddr] <= MemWData;
            else       MemRData     <= mem[MemAddr];
        end
    end

    typedef struct {
        logic          io;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          ir;
        logic [AW-1:0] ia;
        logic          es, eg;
    } vec_t;

    rsp_t sbq[$];
    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string tc, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %h want %h (cycle %0d)", tc, nm, act, exp, cyc);
        end
    endtask

    task automatic step(input string tc, input logic cr, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic ir, input logic [AW-1:0] ia,
                        input logic es, input logic eg);
        logic          cg, ecv, eiv;
        logic [DW-1:0] ed;
        rsp_t          r;
        CpuReq = cr; CpuWe = cw; CpuAddr = ca; CpuWData = cd; IoReq = ir; IoAddr = ia;
        @(negedge CLK);
        cg = cr & ~es;
        chk(tc, "stall", CpuStall, es);
        chk(tc, "iognt", IoGnt, eg);
        chk(tc, "memen", MemEn, cg | eg);
        if (cg | eg) chk(tc, "memaddr", MemAddr, cg ? ca : ia);
        if (cg) begin
            chk(tc, "memwe", MemWe, cw);
            if (cw) chk(tc, "memwdata", MemWData, cd);
        end
        ecv = 1'b0; eiv = 1'b0; ed = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            r   = sbq.pop_front();
            ecv = ~r.io;
            eiv = r.io;
            ed  = r.data;
        end
        chk(tc, "cpurvalid", CpuRValid, ecv);
        chk(tc, "iorvalid", IoRValid, eiv);
        if (ecv) chk(tc, "cpurdata", CpuRData, ed);
        if (eiv) chk(tc, "iordata", IoRData, ed);
        if (cg && !cw) sbq.push_back('{1'b0, smem[ca], cyc + 1});
        else if (eg)   sbq.push_back('{1'b1, smem[ia], cyc + 1});
        if (cg && cw) smem[ca] = cd;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]  = 32'hA000_0000 | i;
            smem[i] = 32'hA000_0000 | i;
        end
        mem[16]  = 32'h0000_0042;
        smem[16] = 32'h0000_0042;

        //              cr    cw    ca      cd             ir    ia      es    eg
        tbl[0] = '{1'b1, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 7'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 7'h05, 32'h0,        1'b0, 7'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 7'h00, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 7'h00, 32'h0,        1'b1, 7'h10, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 7'h00, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 7'h10, 32'h0,        1'b1, 7'h05, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 7'h20, 32'h12345678, 1'b1, 7'h05, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 7'h00, 32'h0,        1'b1, 7'h05, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 7'h20, 32'h0,        1'b0, 7'h00, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 7'h00, 32'h0,        1'b0, 7'h00, 1'b0, 1'b0};

        // Reset held with both requesters active: every output must read zero
        CpuReq = 1'b1; CpuWe = 1'b1; CpuAddr = 7'h7F; CpuWData = 32'hFFFF_FFFF;
        IoReq = 1'b1; IoAddr = 7'h11;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset", "cpustall", CpuStall, 0);
        chk("reset", "cpurvalid", CpuRValid, 0);
        chk("reset", "cpurdata", CpuRData, 0);
        chk("reset", "iognt", IoGnt, 0);
        chk("reset", "iorvalid", IoRValid, 0);
        chk("reset", "iordata", IoRData, 0);
        chk("reset", "memen", MemEn, 0);
        chk("reset", "memwe", MemWe, 0);
        chk("reset", "memaddr", MemAddr, 0);
        chk("reset", "memwdata", MemWData, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        for (int i = 0; i < 10; i++)
            step($sformatf("vec%0d", i), tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                 tbl[i].ir, tbl[i].ia, tbl[i].es, tbl[i].eg);
        chk("hold", "iordata", IoRData, 32'hDEADBEEF);

        // Continuous contention: IO wins every fifth cycle
        for (int i = 0; i < 15; i++)
            step($sformatf("starve%0d", i), 1'b1, 1'b0, AW'(i), 32'h0, 1'b1, 7'h10,
                 (i % 5) == 4, (i % 5) == 4);
        step("starve_idle", 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 1'b0, 1'b0);

        // IO drops after two losing cycles, so the starvation count must restart
        step("drop0", 1'b1, 1'b0, 7'h01, 32'h0, 1'b1, 7'h10, 1'b0, 1'b0);
        step("drop1", 1'b1, 1'b0, 7'h02, 32'h0, 1'b1, 7'h10, 1'b0, 1'b0);
        step("drop2", 1'b1, 1'b0, 7'h03, 32'h0, 1'b0, 7'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step($sformatf("reassert%0d", i), 1'b1, 1'b0, AW'(i + 8), 32'h0, 1'b1, 7'h10,
                 i == 4, i == 4);

        // Move the FSM to IO_PRI with a CPU read in flight, then reset
        for (int i = 0; i < 4; i++)
            step($sformatf("prerst%0d", i), 1'b1, 1'b0, 7'h05, 32'h0, 1'b1, 7'h11, 1'b0, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst", "cpurvalid", CpuRValid, 0);
        chk("midrst", "cpurdata", CpuRData, 0);
        chk("midrst", "iordata", IoRData, 0);
        sbq.delete();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc++;
        step("postrst0", 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 1'b0, 1'b0);
        step("postrst1", 1'b1, 1'b0, 7'h05, 32'h0, 1'b1, 7'h11, 1'b0, 1'b0);
        step("postrst2", 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 1'b0, 1'b0);
        step("postrst3", 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 7'h00, 1'b0, 1'b0);

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
